// File: rtl/mat_io_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : mat_io_sequencer_if
// Brief    : Bundle of the element-input stream, the matrix-multiplier
//            handshake, the result-output stream and the status flags that
//            surround mat_io_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface mat_io_sequencer_if #(
   parameter int N = 2
);

   // element input stream
   logic                   in_valid;
   logic                   in_ready;
   logic [63:0]            in_re;
   logic [63:0]            in_im;

   // multiplier side
   logic [128*N*N-1:0]     mm_mat_a;
   logic [128*N*N-1:0]     mm_mat_b;
   logic                   mm_valid;
   logic                   mm_start;
   logic [128*N*N-1:0]     mm_mat_out;
   logic                   mm_done;

   // result output stream
   logic                   out_valid;
   logic                   out_ready;
   logic                   out_last;
   logic [63:0]            out_re;
   logic [63:0]            out_im;

   // status
   logic                   busy;
   logic                   timeout_err;

   // the sequencer itself
   modport master (
      input  in_valid, in_re, in_im, mm_mat_out, mm_done, out_ready,
      output in_ready, mm_mat_a, mm_mat_b, mm_valid, mm_start,
             out_valid, out_last, out_re, out_im, busy, timeout_err
   );

   // the environment: element source, multiplier and result sink
   modport slave (
      output in_valid, in_re, in_im, mm_mat_out, mm_done, out_ready,
      input  in_ready, mm_mat_a, mm_mat_b, mm_valid, mm_start,
             out_valid, out_last, out_re, out_im, busy, timeout_err
   );

endinterface
`default_nettype wire

// File: rtl/mat_io_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mat_io_sequencer
// Brief    : Collects two N x N complex matrices as a row-major element
//            stream, hands them to an external multiplier with a
//            valid/start handshake, waits (bounded) for the result and
//            streams the N*N result elements back out.
// Revision : 1.0 - initial release
// ============================================================================
module mat_io_sequencer #(
   parameter int N       = 2,
   parameter int TIMEOUT = 1024
) (
   input wire                 clk,
   input wire                 rst,
   mat_io_sequencer_if.master bus
);

   localparam int C_NN   = N * N;
   localparam int C_MW   = 128 * C_NN;      // width of one packed matrix
   localparam int C_IM   = 64 * C_NN;       // offset of the imaginary half
   localparam int C_CW_E = $clog2(C_NN + 1);
   localparam int C_CW_T = $clog2(TIMEOUT + 1);
   // one shared counter serves element index, START length and WAIT length
   localparam int C_CW   = (C_CW_E > C_CW_T) ? C_CW_E : C_CW_T;

   localparam logic [C_CW-1:0] C_ONE     = C_CW'(1);
   localparam logic [C_CW-1:0] C_NN_LAST = C_CW'(C_NN - 1);
   localparam logic [C_CW-1:0] C_TO_LAST = C_CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_A = 3'd1,
      S_LOAD_B = 3'd2,
      S_ISSUE  = 3'd3,
      S_START  = 3'd4,
      S_WAIT   = 3'd5,
      S_DRAIN  = 3'd6
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [C_CW-1:0]   r_cnt;
   logic [C_CW-1:0]   w_cnt_nxt;

   logic [C_MW-1:0]   r_mat_a;
   logic [C_MW-1:0]   r_mat_b;
   logic [C_MW-1:0]   r_result;
   logic              r_timeout_err;

   logic              w_in_ready;
   logic              w_mm_valid;
   logic              w_mm_start;
   logic              w_out_valid;
   logic              w_out_last;
   logic              w_load_a;
   logic              w_load_b;
   logic              w_latch;
   logic              w_to_set;
   logic [63:0]       w_out_re;
   logic [63:0]       w_out_im;

   // state and shared counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // next-state, counter update and Moore-style handshake outputs
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_in_ready  = 1'b0;
      w_mm_valid  = 1'b0;
      w_mm_start  = 1'b0;
      w_out_valid = 1'b0;
      w_out_last  = 1'b0;
      w_load_a    = 1'b0;
      w_load_b    = 1'b0;
      w_latch     = 1'b0;
      w_to_set    = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_state_nxt = S_LOAD_A;
         end

         S_LOAD_A: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) begin
               w_load_a = 1'b1;
               if (r_cnt == C_NN_LAST) begin
                  w_state_nxt = S_LOAD_B;
               end else begin
                  w_cnt_nxt = r_cnt + C_ONE;
               end
            end
         end

         S_LOAD_B: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) begin
               w_load_b = 1'b1;
               if (r_cnt == C_NN_LAST) begin
                  w_state_nxt = S_ISSUE;
               end else begin
                  w_cnt_nxt = r_cnt + C_ONE;
               end
            end
         end

         S_ISSUE: begin
            // valid alone for one cycle before start rises
            w_mm_valid  = 1'b1;
            w_state_nxt = S_START;
         end

         S_START: begin
            // start pulse is exactly two cycles wide; mm_done is ignored here
            w_mm_valid = 1'b1;
            w_mm_start = 1'b1;
            if (r_cnt == C_ONE) begin
               w_state_nxt = S_WAIT;
            end else begin
               w_cnt_nxt = r_cnt + C_ONE;
            end
         end

         S_WAIT: begin
            w_mm_valid = 1'b1;
            if (bus.mm_done) begin
               w_latch     = 1'b1;
               w_state_nxt = S_DRAIN;
            end else if (r_cnt == C_TO_LAST) begin
               // give up: flag it and start over without producing output
               w_to_set    = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + C_ONE;
            end
         end

         S_DRAIN: begin
            w_out_valid = 1'b1;
            w_out_last  = (r_cnt == C_NN_LAST);
            if (bus.out_ready) begin
               if (r_cnt == C_NN_LAST) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_cnt_nxt = r_cnt + C_ONE;
               end
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // every state starts counting from zero
      if (w_state_nxt != r_state) begin
         w_cnt_nxt = '0;
      end
   end

   // operand capture, result capture and sticky timeout flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mat_a       <= '0;
         r_mat_b       <= '0;
         r_result      <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         for (int k = 0; k < C_NN; k++) begin
            if (w_load_a && (int'(r_cnt) == k)) begin
               r_mat_a[64*k +: 64]        <= bus.in_re;
               r_mat_a[C_IM + 64*k +: 64] <= bus.in_im;
            end
            if (w_load_b && (int'(r_cnt) == k)) begin
               r_mat_b[64*k +: 64]        <= bus.in_re;
               r_mat_b[C_IM + 64*k +: 64] <= bus.in_im;
            end
         end
         if (w_latch) begin
            r_result <= bus.mm_mat_out;
         end
         if (w_to_set) begin
            r_timeout_err <= 1'b1;
         end
      end
   end

   // select the result element addressed by the counter; it only moves on a
   // handshake, so the data holds while the sink stalls
   always_comb begin
      w_out_re = '0;
      w_out_im = '0;
      for (int k = 0; k < C_NN; k++) begin
         if (int'(r_cnt) == k) begin
            w_out_re = r_result[64*k +: 64];
            w_out_im = r_result[C_IM + 64*k +: 64];
         end
      end
   end

   assign bus.in_ready    = w_in_ready;
   assign bus.mm_mat_a    = r_mat_a;
   assign bus.mm_mat_b    = r_mat_b;
   assign bus.mm_valid    = w_mm_valid;
   assign bus.mm_start    = w_mm_start;
   assign bus.out_valid   = w_out_valid;
   assign bus.out_last    = w_out_last;
   assign bus.out_re      = w_out_re;
   assign bus.out_im      = w_out_im;
   assign bus.busy        = (r_state != S_IDLE);
   assign bus.timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_mat_io_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mat_io_sequencer
// Brief    : Self-checking bench for mat_io_sequencer: directed job table,
//            partial-load abort, and randomized jobs against a job-level
//            reference model (element lists, expected cycle schedule).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mat_io_sequencer;

   localparam int N   = 2;
   localparam int NN  = N * N;
   localparam int MW  = 128 * NN;
   localparam int TMO = 16;

   typedef struct {
      logic [63:0] re;
      logic [63:0] im;
   } elem_t;

   typedef struct {
      int gap;     // percent chance of an idle input cycle
      int rmode;   // 0: always ready, 1: 1,0,0,1 pattern, 2: random
      int dly;     // WAIT cycle on which mm_done fires, -1 = never
   } job_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic exp_to = 1'b0;

   elem_t dir_in  [2*NN];
   elem_t dir_res [NN];
   job_t  jobs    [6];

   always #5 clk = ~clk;

   mat_io_sequencer_if #(.N(N)) bus ();

   mat_io_sequencer #(.N(N), .TIMEOUT(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h (t=%0t)", nm, got, want, $time);
      end
   endtask

   function automatic logic [MW-1:0] pack(input elem_t e[NN]);
      logic [MW-1:0] p;
      p = '0;
      for (int k = 0; k < NN; k++) begin
         p[64*k +: 64]        = e[k].re;
         p[64*NN + 64*k +: 64] = e[k].im;
      end
      return p;
   endfunction

   function automatic logic [MW-1:0] rand_mat();
      logic [MW-1:0] m;
      for (int i = 0; i < MW/32; i++) m[32*i +: 32] = $urandom;
      return m;
   endfunction

   task automatic check_zero(input string tag);
      chk({tag, "_in_ready"},  bus.in_ready, 0);
      chk({tag, "_mm_valid"},  bus.mm_valid, 0);
      chk({tag, "_mm_start"},  bus.mm_start, 0);
      chk({tag, "_out_valid"}, bus.out_valid, 0);
      chk({tag, "_out_last"},  bus.out_last, 0);
      chk({tag, "_busy"},      bus.busy, 0);
      chk({tag, "_timeout"},   bus.timeout_err, 0);
      chk({tag, "_mat_a"},     64'(|bus.mm_mat_a), 0);
      chk({tag, "_mat_b"},     64'(|bus.mm_mat_b), 0);
      chk({tag, "_out_re"},    bus.out_re, 0);
      chk({tag, "_out_im"},    bus.out_im, 0);
   endtask

   task automatic check_operands(input string tag, input elem_t ain[2*NN]);
      for (int k = 0; k < NN; k++) begin
         chk({tag, "_a_re"}, bus.mm_mat_a[64*k +: 64],         ain[k].re);
         chk({tag, "_a_im"}, bus.mm_mat_a[64*NN + 64*k +: 64], ain[k].im);
         chk({tag, "_b_re"}, bus.mm_mat_b[64*k +: 64],         ain[NN+k].re);
         chk({tag, "_b_im"}, bus.mm_mat_b[64*NN + 64*k +: 64], ain[NN+k].im);
      end
   endtask

   // One complete job, entered and left with the DUT in IDLE.
   task automatic run_job(input elem_t ain[2*NN], input elem_t res[NN],
                          input int gap, input int rmode, input int dly);
      int  b;
      int  cyc;
      int  k;
      logic r;
      chk("idle_busy", bus.busy, 0);
      chk("idle_in_ready", bus.in_ready, 0);
      bus.in_valid = 1'b1;                 // offered in IDLE, must be refused
      bus.in_re    = {$urandom, $urandom};
      bus.in_im    = {$urandom, $urandom};
      tick();
      // load: 2*NN beats, accepted only while in_ready
      b = 0;
      cyc = 0;
      while (b < 2*NN && cyc < 400) begin
         chk("load_in_ready", bus.in_ready, 1);
         chk("load_busy", bus.busy, 1);
         chk("load_mm_valid", bus.mm_valid, 0);
         if ($urandom_range(99) < gap) begin
            bus.in_valid = 1'b0;
            bus.in_re    = {$urandom, $urandom};
            bus.in_im    = {$urandom, $urandom};
         end else begin
            bus.in_valid = 1'b1;
            bus.in_re    = ain[b].re;
            bus.in_im    = ain[b].im;
         end
         tick();
         if (bus.in_valid) b++;
         cyc++;
      end
      if (b < 2*NN) chk("load_bound", 64'(b), 64'(2*NN));
      // keep offering junk: nothing more may be accepted
      bus.in_valid = 1'b1;
      bus.in_re    = {$urandom, $urandom};
      bus.in_im    = {$urandom, $urandom};
      // ISSUE: valid alone; early mm_done must be ignored
      chk("issue_valid", bus.mm_valid, 1);
      chk("issue_start", bus.mm_start, 0);
      chk("issue_in_ready", bus.in_ready, 0);
      check_operands("issue", ain);
      bus.mm_done    = 1'b1;
      bus.mm_mat_out = rand_mat();
      tick();
      for (int s = 0; s < 2; s++) begin
         chk("start_valid", bus.mm_valid, 1);
         chk("start_start", bus.mm_start, 1);
         chk("start_in_ready", bus.in_ready, 0);
         bus.mm_done    = 1'($urandom_range(1));
         bus.mm_mat_out = rand_mat();
         tick();
      end
      bus.mm_done = 1'b0;
      bus.in_valid = 1'b0;
      // WAIT
      for (int w = 0; w < TMO; w++) begin
         chk("wait_valid", bus.mm_valid, 1);
         chk("wait_start", bus.mm_start, 0);
         chk("wait_out_valid", bus.out_valid, 0);
         chk("wait_in_ready", bus.in_ready, 0);
         chk("wait_timeout", bus.timeout_err, exp_to);
         if (w == dly) begin
            bus.mm_done    = 1'b1;
            bus.mm_mat_out = pack(res);
            tick();
            bus.mm_done    = 1'b0;
            bus.mm_mat_out = rand_mat();
            break;
         end
         tick();
      end
      if (dly < 0) begin
         exp_to = 1'b1;
         chk("to_flag", bus.timeout_err, 1);
         chk("to_busy", bus.busy, 0);
         chk("to_mm_valid", bus.mm_valid, 0);
         chk("to_out_valid", bus.out_valid, 0);
         return;
      end
      // DRAIN
      check_operands("drain", ain);
      k = 0;
      cyc = 0;
      while (k < NN && cyc < 200) begin
         chk("drain_out_valid", bus.out_valid, 1);
         chk("drain_mm_valid", bus.mm_valid, 0);
         chk("drain_in_ready", bus.in_ready, 0);
         chk("drain_re", bus.out_re, res[k].re);
         chk("drain_im", bus.out_im, res[k].im);
         chk("drain_last", bus.out_last, 64'(k == NN-1));
         case (rmode)
            0:       r = 1'b1;
            1:       r = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: r = 1'($urandom_range(1));
         endcase
         bus.out_ready = r;
         tick();
         if (r) k++;
         cyc++;
      end
      if (k < NN) chk("drain_bound", 64'(k), 64'(NN));
      bus.out_ready = 1'b0;
      chk("end_busy", bus.busy, 0);
      chk("end_out_valid", bus.out_valid, 0);
      chk("end_timeout", bus.timeout_err, exp_to);
   endtask

   initial begin
      elem_t rin [2*NN];
      elem_t rres[NN];

      bus.in_valid   = 1'b0;
      bus.in_re      = '0;
      bus.in_im      = '0;
      bus.mm_mat_out = '0;
      bus.mm_done    = 1'b0;
      bus.out_ready  = 1'b0;

      // A = identity, B = {1+1j, 2+0j, 0+3j, 4-1j} as IEEE doubles
      dir_in[0] = '{64'h3FF0_0000_0000_0000, 64'h0};
      dir_in[1] = '{64'h0,                   64'h0};
      dir_in[2] = '{64'h0,                   64'h0};
      dir_in[3] = '{64'h3FF0_0000_0000_0000, 64'h0};
      dir_in[4] = '{64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000};
      dir_in[5] = '{64'h4000_0000_0000_0000, 64'h0};
      dir_in[6] = '{64'h0,                   64'h4008_0000_0000_0000};
      dir_in[7] = '{64'h4010_0000_0000_0000, 64'hBFF0_0000_0000_0000};
      for (int k = 0; k < NN; k++) begin
         dir_res[k].re = 64'hC0DE_0000_0000_0000 + 64'(k);
         dir_res[k].im = 64'hBEEF_0000_0000_0010 + 64'(k);
      end
      jobs[0] = '{0,  0, 3};    // mm_done 5 cycles after start rises
      jobs[1] = '{0,  1, 3};    // out_ready 1,0,0,1
      jobs[2] = '{40, 2, 0};    // input gaps, earliest mm_done
      jobs[3] = '{20, 0, 15};   // mm_done on the last allowed WAIT cycle
      jobs[4] = '{0,  0, -1};   // never done: timeout
      jobs[5] = '{30, 1, 7};    // after timeout: flag sticky, job still works

      // reset state
      tick();
      tick();
      check_zero("reset");
      rst = 1'b0;

      for (int j = 0; j < 6; j++) begin
         run_job(dir_in, dir_res, jobs[j].gap, jobs[j].rmode, jobs[j].dly);
      end

      // explicit operand words of the directed job are still in place
      chk("b_word3_re", bus.mm_mat_b[64*3 +: 64], 64'h4010_0000_0000_0000);
      chk("b_word0_im", bus.mm_mat_b[64*NN +: 64], 64'h3FF0_0000_0000_0000);

      // abort after 3 A beats
      tick();
      for (int i = 0; i < 3; i++) begin
         rin[i] = '{{$urandom, $urandom}, {$urandom, $urandom}};
         bus.in_valid = 1'b1;
         bus.in_re    = rin[i].re;
         bus.in_im    = rin[i].im;
         tick();
      end
      bus.in_valid = 1'b0;
      chk("partial_word2", bus.mm_mat_a[64*2 +: 64], rin[2].re);
      rst = 1'b1;
      tick();
      check_zero("abort");
      rst = 1'b0;
      exp_to = 1'b0;
      run_job(dir_in, dir_res, 0, 0, 3);

      // randomized jobs
      for (int j = 0; j < 16; j++) begin
         for (int i = 0; i < 2*NN; i++) rin[i] = '{{$urandom, $urandom}, {$urandom, $urandom}};
         for (int i = 0; i < NN; i++) rres[i] = '{{$urandom, $urandom}, {$urandom, $urandom}};
         run_job(rin, rres, int'($urandom_range(60)), int'($urandom_range(2)),
                 ($urandom_range(9) == 0) ? -1 : int'($urandom_range(15)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
